// File: rtl/jzjpcc_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a toggle-handshake command word, a small byte FIFO and a status word.
// Build option: define JZJPCC_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module jzjpcc_mmio_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] txCommand,
  output logic [31:0] txStatus,
  output logic        uartTx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t          state_reg, state_next;
  logic [BW-1:0]   baud_reg, baud_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic            tx_reg, tx_next;
  logic            busy_next;
  logic [31:0]     status_reg, status_next;

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic            ack_reg, ack_next;

  logic            full, empty, push, pop, baud_last;
  logic            full_next, empty_next;
  logic [3:0]      count_field;
  logic            unused_cmd;

  assign unused_cmd = ^txCommand[31:9];

  assign full      = (count_reg == CW'(FIFO_DEPTH));
  assign empty     = (count_reg == '0);
  assign baud_last = (baud_reg == BW'(CLKS_PER_BIT - 1));

  // A push uses the pre-edge count, so a pop on the same edge cannot open room for it.
  assign push = (txCommand[8] != ack_reg) && !full;
  assign pop  = !empty && ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && baud_last));

  assign ack_next = push ? txCommand[8] : ack_reg;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= txCommand[7:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ack_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
      ack_reg   <= ack_next;
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      status_reg  <= 32'h0000_0400;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      status_reg  <= status_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg + BW'(1);
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    case (state_reg)
      ST_IDLE: begin
        baud_next = '0;
        if (pop) begin
          shift_next = fifo_mem[rd_ptr_reg];
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          state_next   = ST_DATA;
          baud_next    = '0;
          bit_idx_next = '0;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_next = '0;
          if (bit_idx_reg == 3'd7) begin
`ifdef JZJPCC_UART_TX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_last) begin
          state_next = ST_STOP;
          baud_next  = '0;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_next = '0;
          if (pop) begin
            shift_next = fifo_mem[rd_ptr_reg];
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        baud_next  = '0;
      end
    endcase
  end

  // Output logic, looked ahead one edge so the serial line and status are registered
  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_next != ST_IDLE);
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[bit_idx_next];
      ST_PARITY: tx_next = ^shift_next;
      default:   tx_next = 1'b1;
    endcase
  end

  assign full_next   = (count_next == CW'(FIFO_DEPTH));
  assign empty_next  = (count_next == '0);
  assign count_field = 4'(count_next);

  always_comb begin
    status_next        = '0;
    status_next[8]     = ack_next;
    status_next[9]     = full_next;
    status_next[10]    = empty_next;
    status_next[11]    = busy_next;
    status_next[15:12] = count_field;
  end

  assign txStatus = status_reg;
  assign uartTx   = tx_reg;

endmodule

// File: tb/tb_jzjpcc_mmio_uart_tx.sv
// Randomised scoreboard bench: queued bytes are expected, in order, as decoded serial frames on uartTx.
module tb_jzjpcc_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef JZJPCC_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] txCommand = '0;
  logic [31:0] txStatus;
  logic        uartTx;

  int checks = 0;
  int errors = 0;
  byte unsigned exp_q[$];
  longint frame_starts[$];
  longint cyc = 0;
  bit toggle = 1'b0;

  jzjpcc_mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .txCommand(txCommand),
    .txStatus(txStatus),
    .uartTx(uartTx)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic frame_bit(input byte unsigned b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef JZJPCC_UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  // Monitor: decode every frame mid-bit and compare against the scoreboard queue
  initial begin
    logic [10:0] bits;
    logic [10:0] expb;
    bit aborted;
    longint st;
    byte unsigned e;
    forever begin
      @(negedge clock);
      if (reset && uartTx == 1'b0) begin
        bits = '0;
        aborted = 1'b0;
        st = cyc;
        for (int c = 0; c < FRAME; c++) begin
          if (c > 0) @(negedge clock);
          if (!reset) begin
            aborted = 1'b1;
            break;
          end
          if (c % CPB == CPB / 2) bits[c / CPB] = uartTx;
        end
        if (aborted) begin
          $display("info frame abandoned by reset at cycle %0d", st);
          while (!reset) @(negedge clock);
        end else begin
          frame_starts.push_back(st);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame actual=%h required=none", bits);
          end else begin
            e = exp_q.pop_front();
            expb = '0;
            for (int i = 0; i < NBITS; i++) expb[i] = frame_bit(e, i);
            if (bits !== expb) begin
              errors++;
              $display("FAIL frame byte=%h actual_bits=%h required_bits=%h", e, bits, expb);
            end else begin
              $display("ok   frame byte=%h bits=%h start=%0d", e, bits, st);
            end
          end
        end
      end
    end
  end

  task automatic wait_ack();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clock);
      if (txStatus[8] == toggle) return;
    end
    checks++;
    errors++;
    $display("FAIL ack_timeout actual=%b required=%b", txStatus[8], toggle);
  endtask

  task automatic issue(input byte unsigned b);
    toggle = ~toggle;
    txCommand = {23'h0, toggle, b};
    exp_q.push_back(b);
  endtask

  task automatic send(input byte unsigned b);
    issue(b);
    wait_ack();
  endtask

  task automatic drain();
    for (int i = 0; i < 20000; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && txStatus == (32'h0000_0400 | (32'(toggle) << 8))) begin
        checks++;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout actual=%h required=%h queued=%0d", txStatus,
             32'h0000_0400 | (32'(toggle) << 8), exp_q.size());
  endtask

  initial begin
    int n0;
    bit stable;
    byte unsigned d;

    // Reset state and quiet release
    repeat (3) @(negedge clock);
    check32("reset_status", txStatus, 32'h0000_0400);
    check32("reset_tx", {31'h0, uartTx}, 32'h1);
    reset = 1'b1;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (txStatus !== 32'h0000_0400 || uartTx !== 1'b1) stable = 1'b0;
    end
    check32("idle_after_release", {31'h0, stable}, 32'h1);

    // Single byte with exact waveform
    toggle = 1'b1;
    txCommand = 32'h0000_0155;
    exp_q.push_back(8'h55);
    @(negedge clock);
    check32("ack_after_e0", {31'h0, txStatus[8]}, 32'h1);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clock);
      check32($sformatf("wave_c%0d", c), {30'h0, txStatus[11], uartTx},
              {30'h0, 1'b1, frame_bit(8'h55, c / CPB)});
    end
    @(negedge clock);
    check32("status_after_frame", txStatus, 32'h0000_0500);
    drain();

    // Burst: fill FIFO, full refusal, back-to-back frames
    n0 = frame_starts.size();
    for (int i = 0; i < 5; i++) send(byte'(8'h11 + i));
    check32("burst_full", {31'h0, txStatus[9]}, 32'h1);
    check32("burst_count", {28'h0, txStatus[15:12]}, 32'd4);
    issue(8'h16);
    repeat (3) @(negedge clock);
    check32("full_pending_ack", {31'h0, txStatus[8]}, {31'h0, ~toggle});
    check32("full_pending_count", {28'h0, txStatus[15:12]}, 32'd4);
    wait_ack();
    drain();
    check32("burst_frames", frame_starts.size() - n0, 32'd6);
    for (int i = n0 + 1; i < frame_starts.size(); i++)
      check32($sformatf("gap_%0d", i - n0), 32'(frame_starts[i] - frame_starts[i-1]), 32'(FRAME));

    // Data changes with the toggle held produce nothing
    n0 = frame_starts.size();
    send(8'hAA);
    drain();
    txCommand[7:0] = 8'hBB;
    repeat (3 * FRAME) @(negedge clock);
    check32("held_toggle_frames", frame_starts.size() - n0, 32'd1);
    send(8'hBB);
    drain();
    check32("retoggle_frames", frame_starts.size() - n0, 32'd2);

    // Randomised traffic with data-bit noise between toggles
    for (int k = 0; k < 24; k++) begin
      int gap;
      gap = $urandom_range(0, 25);
      for (int g = 0; g < gap; g++) begin
        @(negedge clock);
        txCommand[7:0] = 8'($urandom);
      end
      d = 8'($urandom);
      send(d);
    end
    drain();

    // Reset during a frame
    send(8'h55);
    repeat (10) @(negedge clock);
    reset = 1'b0;
    txCommand = '0;
    toggle = 1'b0;
    #1;
    check32("midframe_reset_tx", {31'h0, uartTx}, 32'h1);
    check32("midframe_reset_status", txStatus, 32'h0000_0400);
    exp_q.delete();
    repeat (10) @(negedge clock);
    n0 = frame_starts.size();
    reset = 1'b1;
    stable = 1'b1;
    repeat (3 * FRAME) begin
      @(negedge clock);
      if (txStatus !== 32'h0000_0400 || uartTx !== 1'b1) stable = 1'b0;
    end
    check32("quiet_after_reset", {31'h0, stable}, 32'h1);
    check32("no_frame_after_reset", frame_starts.size() - n0, 32'd0);

`ifdef JZJPCC_UART_TX_PARITY_EN
    n0 = frame_starts.size();
    send(8'h07);
    send(8'h03);
    drain();
    check32("parity_frames", frame_starts.size() - n0, 32'd2);
    if (frame_starts.size() - n0 == 2)
      check32("parity_frame_len", 32'(frame_starts[n0+1] - frame_starts[n0]), 32'd44);
`endif

    check32("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
